// File: rtl/mem_pkg.sv
// mem_pkg: size codes, MEM-stage FSM states, request bundle and
// little-endian lane extract/merge helpers shared with a later cache.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MERGE,
    WRITE,
    RESP
  } mem_state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic [31:0] lane_extract(
    input logic [31:0] w,
    input logic [1:0]  lane,
    input logic [1:0]  size,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      SIZE_BYTE: r = {{24{sgn & b[7]}}, b};
      SIZE_HALF: r = {{16{sgn & h[15]}}, h};
      default:   r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(
    input logic [31:0] w,
    input logic [31:0] wd,
    input logic [1:0]  lane,
    input logic [1:0]  size
  );
    logic [31:0] r;
    r = w;
    case (size)
      SIZE_BYTE: r[{lane, 3'b000} +: 8] = wd[7:0];
      SIZE_HALF: begin
        if (lane[1]) r[31:16] = wd[15:0];
        else         r[15:0]  = wd[15:0];
      end
      default:   r = wd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational lane extract+extend of a read word and
// lane merge of store data into it. i_word/i_wdata/i_lane/i_size/i_sgn in; o_ext/o_merged out.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_sgn,
  output logic [31:0] o_ext,
  output logic [31:0] o_merged
);

  assign o_ext    = lane_extract(i_word, i_lane,
                                 i_size, i_sgn);
  assign o_merged = lane_merge(i_word, i_wdata,
                               i_lane, i_size);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage controller in front of a sync BRAM.
// Ports: req_* (EX handshake), rsp_* (WB handshake), mem_* (BRAM port A).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [31:0]       mem_dina,
  input  logic [31:0]       mem_douta
);

  localparam logic [1:0] LAT = 2'(MEM_RD_LAT);

  mem_state_t        r_state;
  mem_state_t        w_next;
  mem_req_t          r_req;
  logic [1:0]        r_cnt;
  logic              r_wea;
  logic [ADDR_W-1:0] r_addra;
  logic [31:0]       r_dina;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic              w_acc;
  logic              w_err;
  logic              w_wstore;
  logic              w_cap;
  logic [31:0]       w_ext;
  logic [31:0]       w_merged;

  assign w_acc = req_valid && (r_state == IDLE);

  // Any of these reject the request before touching memory.
  assign w_err =
      (req_size == SIZE_RSVD)
    | ((req_size == SIZE_HALF) & req_addr[0])
    | ((req_size == SIZE_WORD) & (|req_addr[1:0]))
    | (|req_addr[31:ADDR_W+2]);

  assign w_wstore = req_we && (req_size == SIZE_WORD);
  assign w_cap    = (r_state == RD) && (r_cnt == LAT);

  mem_lane_align u_align (
    .i_word   (mem_douta),
    .i_wdata  (r_req.wdata),
    .i_lane   (r_req.lane),
    .i_size   (r_req.size),
    .i_sgn    (r_req.sgn),
    .o_ext    (w_ext),
    .o_merged (w_merged)
  );

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (w_err)         w_next = RESP;
          else if (w_wstore) w_next = WRITE;
          else               w_next = RD;
        end
      end
      RD: begin
        if (w_cap)
          w_next = r_req.we ? MERGE : RESP;
      end
      MERGE:   w_next = RESP;
      WRITE:   w_next = RESP;
      RESP: begin
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= '0;
      r_cnt   <= '0;
      r_wea   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wea <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_req   <= '{we:    req_we,
                         size:  req_size,
                         sgn:   req_signed,
                         lane:  req_addr[1:0],
                         wdata: req_wdata};
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= w_err;
            if (!w_err) begin
              r_addra <= req_addr[ADDR_W+1:2];
              // Word stores skip the read and write straight away.
              if (w_wstore) begin
                r_wea  <= 1'b1;
                r_dina <= req_wdata;
              end
            end
          end
        end
        RD: begin
          if (w_cap) begin
            if (r_req.we) r_dina  <= w_merged;
            else          r_rdata <= w_ext;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        MERGE:   r_wea <= 1'b1;
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign mem_wea   = r_wea;
  assign mem_addra = r_addra;
  assign mem_dina  = r_dina;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives mem_access_unit against a 16x32 BRAM
// model and a byte-address reference memory.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int ADDR_W = 4;

  logic              clka = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_wea;
  logic [ADDR_W-1:0] mem_addra;
  logic [31:0]       mem_dina;
  logic [31:0]       mem_douta;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wea_seen = 0;
  int          w0;
  logic [31:0] rd;
  logic [31:0] bram    [16];
  logic [31:0] ref_mem [16];

  mem_access_unit #(
    .ADDR_W     (ADDR_W),
    .MEM_RD_LAT (1)
  ) dut (
    .clka       (clka),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_wea    (mem_wea),
    .mem_addra  (mem_addra),
    .mem_dina   (mem_dina),
    .mem_douta  (mem_douta)
  );

  always #50 clka = ~clka;

  // Data_Memory: read-first synchronous BRAM, one cycle read latency.
  always @(posedge clka) begin
    if (mem_wea) bram[mem_addra] <= mem_dina;
    mem_douta <= bram[mem_addra];
  end

  always @(negedge clka) if (mem_wea) wea_seen++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic [1:0] sz,
                                   input logic [31:0] ad);
    int nb;
    nb = 1 << sz;
    return (sz == 2'b11) || (ad >= 32'd64)
        || ((ad % nb) != 0);
  endfunction

  function automatic logic [31:0] ref_load(
    input logic [1:0] sz, input logic sg,
    input logic [31:0] ad);
    longint v, span;
    span = longint'(1) << (8 * (1 << sz));
    v = (longint'(ref_mem[ad[5:2]]) >> (8 * (ad % 4)))
        % span;
    if (sg && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [1:0] sz,
                           input logic [31:0] ad,
                           input logic [31:0] wd);
    longint mask, sh;
    sh   = 8 * (ad % 4);
    mask = ((longint'(1) << (8 * (1 << sz))) - 1) << sh;
    ref_mem[ad[5:2]] = 32'(
      (longint'(ref_mem[ad[5:2]]) & ~mask)
      | ((longint'(wd) << sh) & mask));
  endtask

  // One full request/response transaction, checked against the model.
  task automatic step(input string tag,
                      input logic we,
                      input logic [1:0] sz,
                      input logic sg,
                      input logic [31:0] ad,
                      input logic [31:0] wd,
                      input int hold,
                      output logic [31:0] rdo);
    int          t, ws, e_lat, e_wea;
    logic        e_err;
    logic [31:0] e_rd;
    e_err = ref_err(sz, ad);
    e_rd  = (e_err || we) ? 32'h0 : ref_load(sz, sg, ad);
    e_lat = e_err ? 1 : (we && sz == SIZE_WORD) ? 2
          : we ? 4 : 3;
    e_wea = (!e_err && we) ? 1 : 0;
    @(negedge clka);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    rsp_ready  = (hold == 0);
    chk({tag, "/ready"}, 32'(req_ready), 32'h1);
    ws = wea_seen;
    @(posedge clka);
    @(negedge clka);
    req_valid  = 1'b0;
    req_we     = ~we;
    req_size   = 2'($urandom);
    req_signed = ~sg;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(negedge clka);
      t++;
    end
    chk({tag, "/lat"}, 32'(t + 1), 32'(e_lat));
    rdo = rsp_rdata;
    chk({tag, "/rdata"}, rsp_rdata, e_rd);
    chk({tag, "/err"}, 32'(rsp_err), 32'(e_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clka);
      chk({tag, "/hold"},
          {rsp_valid, req_ready, rsp_err},
          {1'b1, 1'b0, e_err});
      chk({tag, "/hold_rd"}, rsp_rdata, e_rd);
    end
    rsp_ready = 1'b1;
    @(posedge clka);
    @(negedge clka);
    rsp_ready = 1'b0;
    chk({tag, "/idle"}, {rsp_valid, req_ready}, 2'b01);
    chk({tag, "/wea"}, 32'(wea_seen - ws), 32'(e_wea));
    if (we && !e_err) ref_store(sz, ad, wd);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clka);
    chk("rst/ready", 32'(req_ready), 32'h1);
    chk("rst/rsp", {rsp_valid, rsp_err}, 2'b00);
    chk("rst/rdata", rsp_rdata, 32'h0);
    chk("rst/wea", 32'(mem_wea), 32'h0);
    chk("rst/addra", 32'(mem_addra), 32'h0);
    chk("rst/dina", mem_dina, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      step($sformatf("pre%0d", i), 1'b1, SIZE_WORD, 1'b0,
           32'(i * 4), $urandom, 0, rd);

    step("t1/st", 1'b1, SIZE_WORD, 1'b0, 32'h08,
         32'hDEADBEEF, 0, rd);
    step("t1/ld", 1'b0, SIZE_WORD, 1'b0, 32'h08,
         32'h0, 0, rd);
    chk("t1/val", rd, 32'hDEADBEEF);

    step("t2/st", 1'b1, SIZE_WORD, 1'b0, 32'h08,
         32'h11223344, 0, rd);
    step("t2/b0B", 1'b0, SIZE_BYTE, 1'b1, 32'h0B,
         32'h0, 0, rd);
    chk("t2/b0B_val", rd, 32'h00000011);
    step("t2/b08", 1'b0, SIZE_BYTE, 1'b1, 32'h08,
         32'h0, 0, rd);
    chk("t2/b08_val", rd, 32'h00000044);
    step("t2/st2", 1'b1, SIZE_WORD, 1'b0, 32'h08,
         32'h80FF0000, 0, rd);
    step("t2/h0A", 1'b0, SIZE_HALF, 1'b1, 32'h0A,
         32'h0, 0, rd);
    chk("t2/h0A_val", rd, 32'hFFFF80FF);

    step("t3/st", 1'b1, SIZE_WORD, 1'b0, 32'h08,
         32'h11223344, 0, rd);
    step("t3/sb", 1'b1, SIZE_BYTE, 1'b0, 32'h09,
         32'h000000AA, 0, rd);
    step("t3/ld", 1'b0, SIZE_WORD, 1'b0, 32'h08,
         32'h0, 0, rd);
    chk("t3/val", rd, 32'h1122AA44);

    step("t4/h05", 1'b0, SIZE_HALF, 1'b1, 32'h05,
         32'h0, 0, rd);
    step("t4/w06", 1'b1, SIZE_WORD, 1'b0, 32'h06,
         32'h12345678, 0, rd);
    step("t4/rsv", 1'b0, SIZE_RSVD, 1'b0, 32'h00,
         32'h0, 0, rd);
    step("t4/a40", 1'b0, SIZE_WORD, 1'b0, 32'h40,
         32'h0, 0, rd);

    step("t5/hold", 1'b0, SIZE_WORD, 1'b0, 32'h08,
         32'h0, 10, rd);

    @(negedge clka);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = SIZE_BYTE;
    req_signed = 1'b0;
    req_addr   = 32'h09;
    req_wdata  = 32'h55;
    rsp_ready  = 1'b1;
    w0 = wea_seen;
    @(posedge clka);
    @(negedge clka);
    req_valid = 1'b0;
    @(posedge clka);
    @(posedge clka);
    #10;
    rst_n = 1'b0;
    #1;
    chk("t6/wea", 32'(mem_wea), 32'h0);
    chk("t6/ready", 32'(req_ready), 32'h1);
    chk("t6/rsp", {rsp_valid, rsp_err}, 2'b00);
    chk("t6/rdata", rsp_rdata, 32'h0);
    chk("t6/addra", 32'(mem_addra), 32'h0);
    chk("t6/dina", mem_dina, 32'h0);
    @(negedge clka);
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clka);
    chk("t6/nowrite", 32'(wea_seen - w0), 32'h0);
    step("t6/rb", 1'b0, SIZE_WORD, 1'b0, 32'h08,
         32'h0, 0, rd);
    chk("t6/rb_val", rd, 32'h1122AA44);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      sz = ($urandom_range(0, 7) == 0) ? 2'b11
         : 2'($urandom_range(0, 2));
      ad = 32'($urandom_range(0, 67));
      if ($urandom_range(0, 15) == 0) ad[31] = 1'b1;
      step($sformatf("rnd%0d", i), 1'($urandom), sz,
           1'($urandom), ad, $urandom, 0, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
